cd4017_decoder: RTL and testbench
=================================

Name: cd4017_decoder

Overview:
- Receive-side checker/decoder for a CD4017-style decade counter: samples the 10-bit one-hot Q bus and the CO line and converts them back to a binary digit.
- Tracks lock to the legal 0..9 sequence, counts decade wrap-arounds for cascading, and flags illegal patterns, sequence skips and CO mismatches.
- Sits beside a decade counter instance in the same clock domain and feeds status/monitor logic.

Parameters:
- WRAP_W, 8: width of the wrap (decade) counter; wraps modulo 2^WRAP_W.
- ERR_W, 4: width of the saturating error counter.
- CHECK_CO, 1: 1 enables CO consistency checking; 0 forces co_err to 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sample_en  input  1  qualifies q_in/co_in as a sample this cycle.
- q_in  input  10  one-hot Q0..Q9 from counter; bit i = digit i.
- co_in  input  1  counter carry-out; legal value is high for digits 0-4, low for 5-9.
- clr  input  1  synchronous clear of counters, lock and flags.
- digit  output  4  last accepted digit, 0..9.
- digit_valid  output  1  digit holds a locked, legal value.
- locked  output  1  FSM in TRACK.
- wrap_pulse  output  1  one-cycle pulse on an accepted 9->0 step.
- wrap_count  output  WRAP_W  number of accepted 9->0 steps.
- onehot_err  output  1  one-cycle pulse: sampled q_in not exactly one bit set.
- seq_err  output  1  one-cycle pulse: illegal step while locked.
- co_err  output  1  one-cycle pulse: co_in inconsistent with the decoded digit.
- err_count  output  ERR_W  saturating count of cycles with any error pulse.

Behaviour:
- Reset (async): state ACQUIRE, digit=0. All of digit_valid, locked, wrap_pulse, wrap_count, onehot_err, seq_err, co_err and err_count are 0.
- All outputs are registered. Response appears the cycle after the sampling edge (1-cycle latency).
- Decode: q_in with exactly one bit set is legal, giving idx = bit position. 0x000 or multi-bit is illegal.
- sample_en=0: state, digit and counters hold; all pulses are 0.
- clr=1 (sync, above sample_en): state ACQUIRE, locked=0, digit_valid=0, wrap_count=0, err_count=0, pulses 0. The sample in that cycle is ignored. digit holds.
- ACQUIRE, legal sample: digit<=idx, digit_valid=1, locked=1, go to TRACK. No sequence check and no wrap in this cycle.
- ACQUIRE, illegal sample: onehot_err pulse; stay in ACQUIRE.
- TRACK, legal, idx==digit: hold with no pulse (counter clock-inhibited).
- TRACK, legal, idx==digit+1 with digit<9: digit<=idx.
- TRACK, legal, digit==9 and idx==0: digit<=0, wrap_pulse=1, wrap_count+1 (mod 2^WRAP_W).
- TRACK, legal, any other idx: seq_err pulse; locked=0, digit_valid=0, go to ACQUIRE; digit holds its old value.
- TRACK, illegal sample: onehot_err pulse; locked=0, digit_valid=0, go to ACQUIRE.
- CO check (CHECK_CO=1): on every legal sampled cycle, expected = (idx<5). A mismatch pulses co_err. It does not affect lock and may coincide with seq_err.
- onehot_err excludes seq_err and co_err in the same cycle.
- err_count increments by exactly 1 per cycle in which any error pulse fires (multiple pulses still count 1). It saturates at 2^ERR_W-1.
- Reset asserted mid-operation clears immediately regardless of clk. The first sample after release is treated as acquisition.

Test Plan:
- Reset, then sample_en=1 with q_in 0x001,0x002,...,0x200,0x001 and correct CO -> digit follows 0..9,0 one cycle later; locked=1 from the first sample; one wrap_pulse on the 9->0 step; wrap_count=1; err_count=0.
- Locked at digit 4 (0x010), then q_in=0x003 -> onehot_err=1, locked=0, err_count=1. Then q_in=0x020 -> reacquire with digit=5, no seq_err.
- Locked at digit 3, then q_in=0x040 (digit 6) -> seq_err=1, digit_valid=0, digit stays 3. Repeat 0x040 -> relock with digit=6.
- q_in=0x001, co_in=0 -> co_err=1, locked=1, digit=0. With CHECK_CO=0 the same stimulus gives co_err=0.
- ERR_W=4: 20 consecutive samples with q_in=0x000 -> err_count=15 (saturated). Then clr=1 for one cycle -> err_count=0, wrap_count=0, locked=0.
- Locked at digit 7 with wrap_count=3, assert reset asynchronously between clock edges -> all outputs 0 immediately. After release, q_in=0x100 -> digit=8, locked=1, no seq_err.

Source files
------------

// File: rtl/cd4017_decoder.sv
// cd4017_decoder: decodes and checks a CD4017-style one-hot Q bus and CO line
//   clk, reset (async, active-high), sample_en qualifies q_in/co_in, clr sync clear
//   digit/digit_valid/locked: tracked digit and lock state
//   wrap_pulse/wrap_count: accepted 9->0 steps
//   onehot_err/seq_err/co_err: error pulses; err_count: saturating error-cycle count
module cd4017_decoder #(
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 4,
    parameter bit CHECK_CO = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic [9:0]        q_in,
    input  logic              co_in,
    input  logic              clr,
    output logic [3:0]        digit,
    output logic              digit_valid,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              onehot_err,
    output logic              seq_err,
    output logic              co_err,
    output logic [ERR_W-1:0]  err_count
);
    localparam logic [0:0] ACQUIRE = 1'b0;
    localparam logic [0:0] TRACK   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [3:0]        digit_q, digit_d, idx;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              wp_q, wp_d, oh_q, oh_d, seq_q, seq_d, co_q, co_d;
    logic              legal;

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 10; i++)
            if (q_in[i]) idx = 4'(i);
        legal = $countones(q_in) == 1;
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        wp_d    = 1'b0;
        oh_d    = 1'b0;
        seq_d   = 1'b0;
        co_d    = 1'b0;
        if (clr) begin
            state_d = ACQUIRE;
            wrap_d  = '0;
            err_d   = '0;
        end else if (sample_en) begin
            if (!legal) begin
                oh_d    = 1'b1;
                state_d = ACQUIRE;
            end else begin
                // CO is high for digits 0-4 on a real CD4017
                co_d = CHECK_CO && (co_in != (idx < 4'd5));
                if (state_q == ACQUIRE) begin
                    digit_d = idx;
                    state_d = TRACK;
                end else if (idx == digit_q) begin
                    digit_d = digit_q;
                end else if (digit_q < 4'd9 && idx == digit_q + 4'd1) begin
                    digit_d = idx;
                end else if (digit_q == 4'd9 && idx == 4'd0) begin
                    digit_d = 4'd0;
                    wp_d    = 1'b1;
                    wrap_d  = wrap_q + 1'b1;
                end else begin
                    seq_d   = 1'b1;
                    state_d = ACQUIRE;
                end
            end
            if ((oh_d || seq_d || co_d) && !(&err_q)) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACQUIRE;
            digit_q <= '0;
            wrap_q  <= '0;
            err_q   <= '0;
            wp_q    <= 1'b0;
            oh_q    <= 1'b0;
            seq_q   <= 1'b0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            wp_q    <= wp_d;
            oh_q    <= oh_d;
            seq_q   <= seq_d;
            co_q    <= co_d;
        end
    end

    assign digit       = digit_q;
    assign locked      = state_q == TRACK;
    assign digit_valid = state_q == TRACK;
    assign wrap_pulse  = wp_q;
    assign wrap_count  = wrap_q;
    assign onehot_err  = oh_q;
    assign seq_err     = seq_q;
    assign co_err      = co_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_cd4017_decoder.sv
// tb_cd4017_decoder: directed self-checking bench for cd4017_decoder
module tb_cd4017_decoder;
    logic       clk = 1'b0, reset = 1'b1, sample_en = 1'b0, co_in = 1'b0, clr = 1'b0;
    logic [9:0] q_in = '0;
    logic [3:0] digit, digit2;
    logic       digit_valid, locked, wrap_pulse, onehot_err, seq_err, co_err;
    logic       digit_valid2, locked2, wrap_pulse2, onehot_err2, seq_err2, co_err2;
    logic [7:0] wrap_count, wrap_count2;
    logic [3:0] err_count, err_count2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    cd4017_decoder #(.WRAP_W(8), .ERR_W(4), .CHECK_CO(1'b1)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .q_in(q_in), .co_in(co_in), .clr(clr),
        .digit(digit), .digit_valid(digit_valid), .locked(locked), .wrap_pulse(wrap_pulse),
        .wrap_count(wrap_count), .onehot_err(onehot_err), .seq_err(seq_err), .co_err(co_err),
        .err_count(err_count));

    cd4017_decoder #(.WRAP_W(8), .ERR_W(4), .CHECK_CO(1'b0)) dut_noco (
        .clk(clk), .reset(reset), .sample_en(sample_en), .q_in(q_in), .co_in(co_in), .clr(clr),
        .digit(digit2), .digit_valid(digit_valid2), .locked(locked2), .wrap_pulse(wrap_pulse2),
        .wrap_count(wrap_count2), .onehot_err(onehot_err2), .seq_err(seq_err2), .co_err(co_err2),
        .err_count(err_count2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [9:0] q, input logic co, input logic en = 1'b1, input logic c = 1'b0);
        q_in = q;
        co_in = co;
        sample_en = en;
        clr = c;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        clr = 1'b0;
    endtask

    task automatic run(input int from, input int to);
        for (int i = from; i <= to; i++) cyc(10'(1 << i), i < 5);
    endtask

    initial begin
        #12;
        chk("rst_digit", 32'(digit), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_valid", 32'(digit_valid), 0);
        chk("rst_wrap", 32'(wrap_count), 0);
        chk("rst_err", 32'(err_count), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            cyc(10'(1 << i), i < 5);
            chk($sformatf("seq_digit%0d", i), 32'(digit), 32'(i));
            chk($sformatf("seq_locked%0d", i), 32'(locked), 1);
            chk($sformatf("seq_nowrap%0d", i), 32'(wrap_pulse), 0);
        end
        cyc(10'h001, 1'b1);
        chk("wrap_digit", 32'(digit), 0);
        chk("wrap_pulse", 32'(wrap_pulse), 1);
        chk("wrap_count", 32'(wrap_count), 1);
        chk("wrap_err", 32'(err_count), 0);
        cyc(10'h000, 1'b0, 1'b0);
        chk("idle_pulse", 32'(wrap_pulse), 0);
        chk("idle_digit", 32'(digit), 0);
        chk("idle_nooh", 32'(onehot_err), 0);

        run(1, 4);
        chk("at4", 32'(digit), 4);
        cyc(10'h003, 1'b0);
        chk("oh_err", 32'(onehot_err), 1);
        chk("oh_locked", 32'(locked), 0);
        chk("oh_errcnt", 32'(err_count), 1);
        chk("oh_noco", 32'(co_err), 0);
        cyc(10'h020, 1'b0);
        chk("reacq_digit", 32'(digit), 5);
        chk("reacq_locked", 32'(locked), 1);
        chk("reacq_noseq", 32'(seq_err), 0);

        cyc(10'h000, 1'b0, 1'b0, 1'b1);
        chk("clr1_err", 32'(err_count), 0);
        chk("clr1_wrap", 32'(wrap_count), 0);
        chk("clr1_locked", 32'(locked), 0);
        chk("clr1_digit", 32'(digit), 5);
        cyc(10'h008, 1'b1);
        chk("at3", 32'(digit), 3);
        cyc(10'h040, 1'b0);
        chk("skip_seq", 32'(seq_err), 1);
        chk("skip_valid", 32'(digit_valid), 0);
        chk("skip_digit", 32'(digit), 3);
        chk("skip_errcnt", 32'(err_count), 1);
        cyc(10'h040, 1'b0);
        chk("relock_locked", 32'(locked), 1);
        chk("relock_digit", 32'(digit), 6);
        chk("relock_noseq", 32'(seq_err), 0);

        cyc(10'h000, 1'b0, 1'b0, 1'b1);
        cyc(10'h001, 1'b0);
        chk("co_err", 32'(co_err), 1);
        chk("co_locked", 32'(locked), 1);
        chk("co_digit", 32'(digit), 0);
        chk("co_errcnt", 32'(err_count), 1);
        chk("noco_err", 32'(co_err2), 0);
        chk("noco_locked", 32'(locked2), 1);

        for (int i = 0; i < 20; i++) cyc(10'h000, 1'b0);
        chk("sat_err", 32'(err_count), 15);
        chk("sat_oh", 32'(onehot_err), 1);
        chk("sat_locked", 32'(locked), 0);
        cyc(10'h000, 1'b0, 1'b1, 1'b1);
        chk("clr_err", 32'(err_count), 0);
        chk("clr_wrap", 32'(wrap_count), 0);
        chk("clr_locked", 32'(locked), 0);
        chk("clr_nooh", 32'(onehot_err), 0);

        cyc(10'h200, 1'b0);
        run(0, 9);
        run(0, 9);
        run(0, 7);
        chk("pre_rst_digit", 32'(digit), 7);
        chk("pre_rst_wrap", 32'(wrap_count), 3);
        chk("pre_rst_locked", 32'(locked), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_digit", 32'(digit), 0);
        chk("arst_locked", 32'(locked), 0);
        chk("arst_wrap", 32'(wrap_count), 0);
        chk("arst_err", 32'(err_count), 0);
        #1 reset = 1'b0;
        cyc(10'h100, 1'b0);
        chk("post_digit", 32'(digit), 8);
        chk("post_locked", 32'(locked), 1);
        chk("post_noseq", 32'(seq_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
